// File: rtl/sap_display_pkg.sv
// Shared seven-segment constants for the SAP display path.
// Segment codes are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package sap_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/sap_bcd_to_seg.sv
// Combinational BCD nibble to active-high seven-segment code.
// Non-BCD nibbles (10..15) render as a dash so bad data stays visible.
module sap_bcd_to_seg
  import sap_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sap_seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-frame snapshot,
// leading-zero blanking and a dark interval at the start of every digit slot.
module sap_seven_seg_scanner
  import sap_display_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           BCD_IN,
  input  logic                  enable,
  output logic [6:0]            SEG,
  output logic [NUM_DIGITS-1:0] DIG,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [15:0]           snap;
  logic                  en_q;

  logic                  slot_end;
  logic                  first;
  logic                  load;
  logic [15:0]           src;
  logic [3:0]            nib;
  logic [6:0]            code;
  logic                  lead_blank;
  logic                  lit;
  logic [6:0]            seg_p0;
  logic [NUM_DIGITS-1:0] dig_p0;

  assign slot_end = (cnt == CNT_W'(CLK_DIV - 1));
  assign first    = enable & ~en_q;
  assign load     = enable & (first | (slot_end & (idx == IDX_W'(NUM_DIGITS - 1))));

  // On the restart cycle the old snapshot is stale, so decode straight from BCD_IN.
  assign src = first ? BCD_IN : snap;
  assign nib = src[{idx, 2'b00} +: 4];

  sap_bcd_to_seg u_dec (
    .nibble (nib),
    .seg    (code)
  );

  // Digit k is blanked when it and everything above it are zero; digit 0 never is.
  always_comb begin
    lead_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (idx == IDX_W'(k)) lead_blank = ((src >> (4 * k)) == 16'h0000);
    end
    if (BLANK_LEADING == 0) lead_blank = 1'b0;
  end

  always_comb begin
    lit    = enable & (cnt >= CNT_W'(BLANK_CYCLES)) & ~lead_blank;
    seg_p0 = SEG_OFF;
    dig_p0 = '0;
    if (lit) begin
      seg_p0      = code;
      dig_p0[idx] = 1'b1;
    end
  end

  // Stage p0 -> p1: scan state, snapshot and polarity-adjusted output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      en_q       <= 1'b0;
      snap       <= 16'h0000;
      SEG        <= SEG_OFF ^ SEG_POL;
      DIG        <= DIG_POL;
      frame_tick <= 1'b0;
    end else begin
      en_q       <= enable;
      frame_tick <= load;
      SEG        <= seg_p0 ^ SEG_POL;
      DIG        <= dig_p0 ^ DIG_POL;
      if (load) snap <= BCD_IN;
      if (!enable) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sap_seven_seg_scanner.sv
// Directed bench for sap_seven_seg_scanner with CLK_DIV=8, BLANK_CYCLES=2, active-low pins.
// n counts clock edges from the first snapshot; outputs after edge n reflect scan position n.
module tb_sap_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] BCD_IN;
  logic        enable;
  logic [6:0]  SEG;
  logic [3:0]  DIG;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  // Hand-computed active-low segment codes per slot (index 0 = units) and lit masks.
  localparam logic [6:0] P1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [6:0] P0007 [4] = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [6:0] P0042 [4] = '{7'h24, 7'h19, 7'h7F, 7'h7F};
  localparam logic [6:0] P0099 [4] = '{7'h10, 7'h10, 7'h7F, 7'h7F};
  localparam logic [6:0] P00A5 [4] = '{7'h12, 7'h3F, 7'h7F, 7'h7F};
  localparam logic [6:0] P0567 [4] = '{7'h78, 7'h02, 7'h12, 7'h7F};
  localparam logic [6:0] P0321 [4] = '{7'h79, 7'h24, 7'h30, 7'h7F};

  logic [6:0] exp_seg [4];
  logic [3:0] exp_lit;
  logic [3:0] exp_dig;
  logic [6:0] exp_sg;
  logic       exp_tick;
  int         slot;
  int         c;
  int         lit_cnt [4];

  sap_seven_seg_scanner #(
    .CLK_DIV        (8),
    .BLANK_CYCLES   (2),
    .BLANK_LEADING  (1),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .BCD_IN     (BCD_IN),
    .enable     (enable),
    .SEG        (SEG),
    .DIG        (DIG),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    BCD_IN = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (SEG !== 7'h7F || DIG !== 4'hF || frame_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: SEG=%h DIG=%h tick=%b, want SEG=7f DIG=f tick=0", SEG, DIG, frame_tick);
      end
    end
    reset = 1'b0;
  endtask

  // Frames 0-1: steady 1234, per-digit duty and one-hot digit enables.
  task automatic test_scan();
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
    exp_seg = P1234;
    exp_lit = 4'b1111;
    for (int n = 0; n < 64; n++) begin
      step();
      slot = (n % 32) / 8;
      c    = n % 8;
      exp_dig = 4'hF;
      exp_sg  = 7'h7F;
      if (c >= 2 && exp_lit[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_sg = exp_seg[slot];
      end
      exp_tick = (n == 0) || (n % 32 == 31);
      vectors++;
      if (DIG !== exp_dig || SEG !== exp_sg) begin
        miscompares++;
        $display("FAIL scan n=%0d: DIG=%h SEG=%h, want DIG=%h SEG=%h", n, DIG, SEG, exp_dig, exp_sg);
      end
      vectors++;
      if (frame_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL scan_tick n=%0d: tick=%b, want %b", n, frame_tick, exp_tick);
      end
      vectors++;
      if ($countones(~DIG) > 1) begin
        miscompares++;
        $display("FAIL dig_onehot n=%0d: DIG=%h, want at most one low bit", n, DIG);
      end
      for (int k = 0; k < 4; k++) if (DIG[k] === 1'b0) lit_cnt[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (lit_cnt[k] != 12) begin
        miscompares++;
        $display("FAIL duty digit%0d: lit %0d cycles, want 12", k, lit_cnt[k]);
      end
    end
    BCD_IN = 16'h0007;
  endtask

  // Frame 2 still 1234 (snapshot taken before the change), frame 3 shows only "7".
  task automatic test_leading_zero();
    for (int n = 64; n < 128; n++) begin
      step();
      if (n / 32 == 2) begin exp_seg = P1234; exp_lit = 4'b1111; end
      else begin exp_seg = P0007; exp_lit = 4'b0001; end
      slot = (n % 32) / 8;
      c    = n % 8;
      exp_dig = 4'hF;
      exp_sg  = 7'h7F;
      if (c >= 2 && exp_lit[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_sg = exp_seg[slot];
      end
      exp_tick = (n % 32 == 31);
      vectors++;
      if (DIG !== exp_dig || SEG !== exp_sg || frame_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL leading_zero n=%0d: DIG=%h SEG=%h tick=%b, want DIG=%h SEG=%h tick=%b",
                 n, DIG, SEG, frame_tick, exp_dig, exp_sg, exp_tick);
      end
    end
    BCD_IN = 16'h0042;
  endtask

  // Frame 4 = 0007, frame 5 = 42 even though BCD_IN flips to 99 during digit 1, frame 6 = 99.
  task automatic test_midframe();
    for (int n = 128; n < 224; n++) begin
      step();
      if (n / 32 == 4) begin exp_seg = P0007; exp_lit = 4'b0001; end
      else if (n / 32 == 5) begin exp_seg = P0042; exp_lit = 4'b0011; end
      else begin exp_seg = P0099; exp_lit = 4'b0011; end
      slot = (n % 32) / 8;
      c    = n % 8;
      exp_dig = 4'hF;
      exp_sg  = 7'h7F;
      if (c >= 2 && exp_lit[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_sg = exp_seg[slot];
      end
      exp_tick = (n % 32 == 31);
      vectors++;
      if (DIG !== exp_dig || SEG !== exp_sg || frame_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL midframe n=%0d: DIG=%h SEG=%h tick=%b, want DIG=%h SEG=%h tick=%b",
                 n, DIG, SEG, frame_tick, exp_dig, exp_sg, exp_tick);
      end
      if (n == 170) BCD_IN = 16'h0099;
    end
    BCD_IN = 16'h00A5;
  endtask

  // Frame 7 = 99, frame 8 = "-5" with the invalid nibble shown as a dash.
  task automatic test_dash();
    for (int n = 224; n < 288; n++) begin
      step();
      if (n / 32 == 7) begin exp_seg = P0099; exp_lit = 4'b0011; end
      else begin exp_seg = P00A5; exp_lit = 4'b0011; end
      slot = (n % 32) / 8;
      c    = n % 8;
      exp_dig = 4'hF;
      exp_sg  = 7'h7F;
      if (c >= 2 && exp_lit[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_sg = exp_seg[slot];
      end
      exp_tick = (n % 32 == 31);
      vectors++;
      if (DIG !== exp_dig || SEG !== exp_sg || frame_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL dash n=%0d: DIG=%h SEG=%h tick=%b, want DIG=%h SEG=%h tick=%b",
                 n, DIG, SEG, frame_tick, exp_dig, exp_sg, exp_tick);
      end
    end
    BCD_IN = 16'h0567;
  endtask

  // Drop enable at idx=2 cnt=5, hold low 10 cycles, restart with fresh 0321, then async reset.
  task automatic test_enable();
    for (int n = 288; n < 341; n++) begin
      step();
      if (n / 32 == 9) begin exp_seg = P00A5; exp_lit = 4'b0011; end
      else begin exp_seg = P0567; exp_lit = 4'b0111; end
      slot = (n % 32) / 8;
      c    = n % 8;
      exp_dig = 4'hF;
      exp_sg  = 7'h7F;
      if (c >= 2 && exp_lit[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_sg = exp_seg[slot];
      end
      exp_tick = (n % 32 == 31);
      vectors++;
      if (DIG !== exp_dig || SEG !== exp_sg || frame_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL pre_disable n=%0d: DIG=%h SEG=%h tick=%b, want DIG=%h SEG=%h tick=%b",
                 n, DIG, SEG, frame_tick, exp_dig, exp_sg, exp_tick);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (DIG !== 4'hF || SEG !== 7'h7F || frame_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL disabled k=%0d: DIG=%h SEG=%h tick=%b, want DIG=f SEG=7f tick=0",
                 k, DIG, SEG, frame_tick);
      end
      if (k == 0) BCD_IN = 16'h0321;
    end
    enable  = 1'b1;
    exp_seg = P0321;
    exp_lit = 4'b0111;
    for (int m = 0; m < 13; m++) begin
      step();
      slot = m / 8;
      c    = m % 8;
      exp_dig = 4'hF;
      exp_sg  = 7'h7F;
      if (c >= 2 && exp_lit[slot]) begin
        exp_dig[slot] = 1'b0;
        exp_sg = exp_seg[slot];
      end
      exp_tick = (m == 0);
      vectors++;
      if (DIG !== exp_dig || SEG !== exp_sg || frame_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL restart m=%0d: DIG=%h SEG=%h tick=%b, want DIG=%h SEG=%h tick=%b",
                 m, DIG, SEG, frame_tick, exp_dig, exp_sg, exp_tick);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (DIG !== 4'hF || SEG !== 7'h7F || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: DIG=%h SEG=%h tick=%b, want DIG=f SEG=7f tick=0", DIG, SEG, frame_tick);
    end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_midframe();
    test_dash();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
